psum_out_router_buf: RTL

- ID-filtered partial-sum output router with an elastic FIFO between one PE and the shared psum bus.
- Captures a destination ID during configuration and accepts PE psums only while the presented source_id matches it.
- Buffers accepted psums in a FIFO and drains them with a valid/ready handshake, so bus back-pressure does not drop data.
- Forwards the psum-out start token with the same latency as the data path.

---
 rtl/psum_out_router_buf.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/psum_out_router_buf.sv
// -----------------------------------------------------------------------------
// psum_out_router_buf
//
// Partial-sum output router for one PE. A destination ID is captured during
// configuration; PE psums are accepted only while the presented source_id
// matches it. Accepted words go into a small show-ahead FIFO that drains onto
// the shared psum bus with a valid/ready handshake, so bus back-pressure does
// not lose data. The psum-out start token is forwarded with one register of
// latency, matching the 1-cycle push-to-visible latency of the data path.
//
// Optional build macro: PSUM_ROUTER_MCAST_EN
//   Adds id_mask. A mask is captured with the ID, and only the source_id bits
//   whose mask bit is 1 are compared, so one router can capture a group of IDs.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   config_state, ce    ID load strobe (config_state && ce); also flushes FIFO
//   dest_id             ID to capture
//   id_mask             compare mask to capture (PSUM_ROUTER_MCAST_EN only)
//   source_id           ID of the psum source currently presenting data
//   data_from_pe(_en)   psum word and its valid strobe
//   psum_out_start_in   start token in
//   psum_out_start_out  start token out, registered 1-cycle pulse
//   data_to_bus         FIFO head word, 0 when empty
//   data_to_bus_valid   FIFO not empty
//   bus_ready           bus accepts the head word this cycle
//   fifo_full           FIFO holds FIFO_DEPTH words
//   overflow_err        sticky: a matched psum was dropped on a full FIFO
//   fwd_count           words popped since the last start token (saturating)
// -----------------------------------------------------------------------------
module psum_out_router_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  config_state,
  input  logic                  ce,
  input  logic [ID_WIDTH-1:0]   dest_id,
`ifdef PSUM_ROUTER_MCAST_EN
  input  logic [ID_WIDTH-1:0]   id_mask,
`endif
  input  logic [ID_WIDTH-1:0]   source_id,
  input  logic [DATA_WIDTH-1:0] data_from_pe,
  input  logic                  data_from_pe_en,
  input  logic                  psum_out_start_in,
  output logic                  psum_out_start_out,
  output logic [DATA_WIDTH-1:0] data_to_bus,
  output logic                  data_to_bus_valid,
  input  logic                  bus_ready,
  output logic                  fifo_full,
  output logic                  overflow_err,
  output logic [CNT_WIDTH-1:0]  fwd_count
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  // One extra pointer bit distinguishes full (MSBs differ) from empty (equal).
  localparam int PTR_W  = ADDR_W + 1;

  // State
  logic [ID_WIDTH-1:0]   stored_id_q,   stored_id_d;
  logic [ID_WIDTH-1:0]   stored_mask_q, stored_mask_d;
  logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
  logic                  overflow_q,    overflow_d;
  logic [CNT_WIDTH-1:0]  fwd_cnt_q,     fwd_cnt_d;
  logic                  start_q,       start_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // Control
  logic load;
  logic match;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;
  logic start_fire;

  assign load = config_state & ce;

`ifdef PSUM_ROUTER_MCAST_EN
  assign match = ((stored_id_q ^ source_id) & stored_mask_q) == '0;
`else
  assign match = (stored_id_q == source_id);
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign pop        = ~empty & bus_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a push alongside it.
  assign push       = data_from_pe_en & match & (~full | pop);
  assign drop       = data_from_pe_en & match & full & ~pop;
  assign start_fire = psum_out_start_in & match;

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    stored_id_d   = stored_id_q;
    stored_mask_d = stored_mask_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    fwd_cnt_d     = fwd_cnt_q;
    start_d       = start_fire;

    if (load) begin
      // Reconfiguration discards buffered words and any push in this cycle.
      stored_id_d = dest_id;
`ifdef PSUM_ROUTER_MCAST_EN
      stored_mask_d = id_mask;
`endif
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
      fwd_cnt_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (drop) overflow_d = 1'b1;

      // A start token restarts the count; a pop in the same cycle is the
      // first word of the new burst.
      if (start_fire)
        fwd_cnt_d = pop ? CNT_WIDTH'(1) : '0;
      else if (pop && (fwd_cnt_q != {CNT_WIDTH{1'b1}}))
        fwd_cnt_d = fwd_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Control/status registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from before the edge.
    if (!rst_n) begin
      stored_id_q   <= '0;
      stored_mask_q <= '1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      fwd_cnt_q     <= '0;
      start_q       <= 1'b0;
    end else begin
      stored_id_q   <= stored_id_d;
      stored_mask_q <= stored_mask_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      fwd_cnt_q     <= fwd_cnt_d;
      start_q       <= start_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers define which entries
  // are valid, and the empty case forces data_to_bus to 0.
  always_ff @(posedge clk) begin
    if (push && !load)
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_from_pe;
  end

  // Outputs
  assign data_to_bus        = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign data_to_bus_valid  = ~empty;
  assign fifo_full          = full;
  assign overflow_err       = overflow_q;
  assign fwd_count          = fwd_cnt_q;
  assign psum_out_start_out = start_q;

`ifndef PSUM_ROUTER_MCAST_EN
  // Mask register is tied to all-ones without the multicast feature.
  logic unused_mask;
  assign unused_mask = ^stored_mask_q;
`endif

endmodule
